// File: rtl/ia_ser_pkg.sv
// Shared types and constants for the CIM column input serializer.
//   state_e        : serializer FSM states
//   plane_t        : bit-plane index for the default activation width
//   COL_PIPE_DEPTH : column latency from ia to accumulator input (ia reg + treesum reg)
//   ACC_DEPTH      : accumulator register latency before the sum is observable
package ia_ser_pkg;

  localparam int unsigned NROWS_DEF      = 64;
  localparam int unsigned ABITS_DEF      = 8;
  localparam int unsigned LOG2_ABITS_DEF = 3;
  localparam int unsigned WORDLEN_DEF    = 8;

  localparam int unsigned COL_PIPE_DEPTH = 2;
  localparam int unsigned ACC_DEPTH      = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  typedef logic [LOG2_ABITS_DEF-1:0] plane_t;

endpackage

// File: rtl/ia_align_pipe.sv
// Delay line that lines plane metadata up with the column's accumulator input.
//   clock, reset          : clock, synchronous active-high reset (clears every stage)
//   valid_i/first_i/last_i: plane present on ia / first plane / last plane of vector
//   shift_i               : plane index of the plane on ia
//   shift_o, col_clear_o  : metadata delayed by DEPTH cycles
//   sum_valid_o           : delayed last, plus ACC_DEPTH for the accumulator register
//   active_o              : any stage still holds a plane or a pending completion
module ia_align_pipe
  import ia_ser_pkg::*;
#(
  parameter int unsigned WORDLEN = WORDLEN_DEF,
  parameter int unsigned DEPTH   = COL_PIPE_DEPTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               valid_i,
  input  logic               first_i,
  input  logic               last_i,
  input  logic [WORDLEN-1:0] shift_i,
  output logic [WORDLEN-1:0] shift_o,
  output logic               col_clear_o,
  output logic               sum_valid_o,
  output logic               active_o
);

  logic [DEPTH-1:0]              valid_q;
  logic [DEPTH-1:0]              first_q;
  logic [DEPTH-1:0]              last_q;
  logic [DEPTH-1:0][WORDLEN-1:0] shift_q;
  logic [ACC_DEPTH-1:0]          done_q;

  // Metadata is qualified by valid at entry so idle stages carry shift=0.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      first_q <= '0;
      last_q  <= '0;
      shift_q <= '0;
      done_q  <= '0;
    end else begin
      valid_q[0] <= valid_i;
      first_q[0] <= valid_i & first_i;
      last_q[0]  <= valid_i & last_i;
      shift_q[0] <= valid_i ? shift_i : '0;
      for (int unsigned s = 1; s < DEPTH; s++) begin
        valid_q[s] <= valid_q[s-1];
        first_q[s] <= first_q[s-1];
        last_q[s]  <= last_q[s-1];
        shift_q[s] <= shift_q[s-1];
      end
      done_q[0] <= last_q[DEPTH-1];
      for (int unsigned s = 1; s < ACC_DEPTH; s++) begin
        done_q[s] <= done_q[s-1];
      end
    end
  end

  assign shift_o     = shift_q[DEPTH-1];
  assign col_clear_o = first_q[DEPTH-1];
  assign sum_valid_o = done_q[ACC_DEPTH-1];
  assign active_o    = (|valid_q) | (|done_q);

endmodule

// File: rtl/ia_serializer.sv
// Bit-serial activation feeder for one CIM column.
// Accepts a vector of NROWS unsigned ABITS-bit activations and drives it onto
// ia one bit-plane per cycle, LSB first, with shift/col_clear/sum_valid aligned
// to the column's internal pipeline.
//   clock, reset : clock, synchronous active-high reset
//   act, in_valid, in_ready : input vector handshake
//   ia           : current bit-plane (registered, zero when idle)
//   shift        : plane index at the column accumulator input
//   col_clear    : first plane of a vector at the accumulator input
//   sum_valid    : column sum is final this cycle
//   busy         : a plane is in flight anywhere
// Build option: define IA_ZSKIP_EN to skip bit-planes that are zero in every row.
module ia_serializer
  import ia_ser_pkg::*;
#(
  parameter int unsigned NROWS      = NROWS_DEF,
  parameter int unsigned ABITS      = ABITS_DEF,
  parameter int unsigned LOG2_ABITS = LOG2_ABITS_DEF,
  parameter int unsigned WORDLEN    = WORDLEN_DEF
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NROWS-1:0][ABITS-1:0] act,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [NROWS-1:0]            ia,
  output logic [WORDLEN-1:0]          shift,
  output logic                        col_clear,
  output logic                        sum_valid,
  output logic                        busy
);

  state_e                      state_q, state_d;
  logic [LOG2_ABITS-1:0]       k_q, k_d;
  logic [NROWS-1:0][ABITS-1:0] act_q, act_d;
  logic [NROWS-1:0]            ia_q, ia_d;
  logic                        first_q, first_d;
  logic                        take_c;
  logic                        last_c;
  logic [LOG2_ABITS-1:0]       k_first_c;
  logic [LOG2_ABITS-1:0]       k_next_c;
  logic                        pipe_active;

  function automatic logic [NROWS-1:0] plane_of(input logic [NROWS-1:0][ABITS-1:0] a,
                                                input logic [LOG2_ABITS-1:0]     k);
    for (int unsigned r = 0; r < NROWS; r++) begin
      plane_of[r] = a[r][k];
    end
  endfunction

`ifdef IA_ZSKIP_EN
  // One extra bit so "no further plane" can be encoded as ABITS.
  localparam int unsigned KW = LOG2_ABITS + 1;

  logic [ABITS-1:0] mask_q, mask_d;
  logic [ABITS-1:0] mask_in_c;
  logic [KW-1:0]    nxt_c;

  // Lowest set mask bit at or above 'from', or ABITS if none.
  function automatic logic [KW-1:0] next_plane(input logic [ABITS-1:0] m,
                                               input logic [KW-1:0]    from);
    next_plane = KW'(ABITS);
    for (int j = int'(ABITS) - 1; j >= 0; j--) begin
      if (m[j] && (KW'(j) >= from)) next_plane = KW'(j);
    end
  endfunction

  // An all-zero vector still visits plane 0 so the column sees clear and completion.
  always_comb begin
    mask_in_c = '0;
    for (int unsigned r = 0; r < NROWS; r++) begin
      mask_in_c = mask_in_c | act[r];
    end
    if (mask_in_c == '0) mask_in_c = ABITS'(1);
  end

  assign nxt_c     = next_plane(mask_q, {1'b0, k_q} + KW'(1));
  assign last_c    = (nxt_c == KW'(ABITS));
  assign k_next_c  = LOG2_ABITS'(nxt_c);
  assign k_first_c = LOG2_ABITS'(next_plane(mask_in_c, '0));
`else
  assign last_c    = (k_q == LOG2_ABITS'(ABITS - 1));
  assign k_next_c  = k_q + LOG2_ABITS'(1);
  assign k_first_c = '0;
`endif

  assign in_ready = (state_q == IDLE) || last_c;
  assign take_c   = in_valid && in_ready;

  // Next-state: advance through planes; a transfer in the last plane restarts at once.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    act_d   = act_q;
    first_d = 1'b0;
    ia_d    = '0;
`ifdef IA_ZSKIP_EN
    mask_d  = mask_q;
`endif
    if (state_q == SHIFT) begin
      if (last_c) begin
        state_d = IDLE;
        k_d     = '0;
      end else begin
        k_d = k_next_c;
      end
    end
    if (take_c) begin
      state_d = SHIFT;
      act_d   = act;
      k_d     = k_first_c;
      first_d = 1'b1;
`ifdef IA_ZSKIP_EN
      mask_d  = mask_in_c;
`endif
    end
    if (state_d == SHIFT) ia_d = plane_of(act_d, k_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      act_q   <= '0;
      ia_q    <= '0;
      first_q <= 1'b0;
`ifdef IA_ZSKIP_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      act_q   <= act_d;
      ia_q    <= ia_d;
      first_q <= first_d;
`ifdef IA_ZSKIP_EN
      mask_q  <= mask_d;
`endif
    end
  end

  ia_align_pipe #(
    .WORDLEN(WORDLEN),
    .DEPTH  (COL_PIPE_DEPTH)
  ) u_align (
    .clock      (clock),
    .reset      (reset),
    .valid_i    (state_q == SHIFT),
    .first_i    (first_q),
    .last_i     (last_c),
    .shift_i    (WORDLEN'(k_q)),
    .shift_o    (shift),
    .col_clear_o(col_clear),
    .sum_valid_o(sum_valid),
    .active_o   (pipe_active)
  );

  assign ia   = ia_q;
  assign busy = (state_q == SHIFT) || pipe_active;

endmodule
